// File: rtl/oa_writer_if.sv
// ICB write-bus bundle between oa_writer (master) and the memory-side fabric (slave).
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready handshake on the command side; responses are always accepted.
interface oa_writer_if #(
  parameter int REG_WIDTH = 32,
  parameter int BUS_WIDTH = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [REG_WIDTH-1:0]   cmd_addr;
  logic                   cmd_read;
  logic [BUS_WIDTH-1:0]   cmd_wdata;
  logic [BUS_WIDTH/8-1:0] cmd_wmask;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err
  );
endinterface

// File: rtl/oa_writer.sv
// Output-activation writer: queues requantized int8 rows, writes each full SIZExSIZE tile over ICB.
// Latency: burst starts 2 cycles after SIZE rows are queued (given grant); then one word per cycle.
// Backpressure: oa_row_ready drops when the row FIFO is full; ICB commands stall on cmd_ready/grant.
// Ports: clk/rst_n; init_cfg_oa + cfg_* start a layer; oa_row_* row input; write_oa_req/granted
//        arbitration with mma_controller; write_done/oa_calc_over/oa_err status; icb = ICB master.
module oa_writer #(
  parameter int SIZE      = 16,
  parameter int BUS_WIDTH = 32,
  parameter int REG_WIDTH = 32,
  parameter int ROW_DEPTH = 2 * SIZE,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_cfg_oa,
  input  logic [REG_WIDTH-1:0] cfg_oa_base,
  input  logic [REG_WIDTH-1:0] cfg_oa_stride,
  input  logic [REG_WIDTH-1:0] cfg_tile_count,
  input  logic                 oa_row_valid,
  input  logic [SIZE*8-1:0]    oa_row_data,
  output logic                 oa_row_ready,
  output logic                 fifo_full_flag,
  output logic                 write_oa_req,
  input  logic                 write_oa_granted,
  output logic                 write_done,
  output logic                 oa_calc_over,
  output logic                 oa_err,
  oa_writer_if.master          icb
);
  localparam int ROW_W = SIZE * 8;
  localparam int WPR   = ROW_W / BUS_WIDTH;
  localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW    = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int OW    = $clog2(MAX_OUTST + 1);
  localparam int BYTES = BUS_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_BURST, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WW-1:0]        word_q, word_d;
  logic [RW-1:0]        row_q, row_d;
  logic [REG_WIDTH-1:0] row_addr_q, row_addr_d;
  logic [REG_WIDTH-1:0] stride_q, stride_d;
  logic [REG_WIDTH-1:0] tiles_q, tiles_d;
  logic [REG_WIDTH-1:0] tile_q, tile_d;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 hold_q, hold_d;
  logic                 err_q, err_d;
  logic                 zero_over_q, zero_over_d;

  logic [ROW_W-1:0]                fifo_mem [ROW_DEPTH];
  logic [WPR-1:0][BUS_WIDTH-1:0]   head_words;
  logic push, pop, cmd_vld, cmd_hs, last_word, last_row, last_tile, init_acc;

  assign fifo_full_flag = (cnt_q == CW'(ROW_DEPTH));
  assign oa_row_ready   = !fifo_full_flag;
  assign push           = oa_row_valid && oa_row_ready;
  assign head_words     = fifo_mem[rd_ptr_q];

  assign last_word = (word_q == WW'(WPR - 1));
  assign last_row  = (row_q == RW'(SIZE - 1));
  assign last_tile = (tile_q == tiles_q - 1'b1);
  assign init_acc  = (state_q == S_IDLE) && init_cfg_oa;

  // Once a command is presented it stays up until accepted, even if the
  // grant drops or the outstanding window fills in the meantime.
  assign cmd_vld = (state_q == S_BURST) &&
                   (hold_q || (write_oa_granted && (outst_q < OW'(MAX_OUTST))));
  assign cmd_hs  = cmd_vld && icb.cmd_ready;
  // The head row leaves the FIFO when its last word is accepted.
  assign pop     = cmd_hs && last_word;

  assign icb.cmd_valid = cmd_vld;
  assign icb.cmd_addr  = row_addr_q + (REG_WIDTH'(word_q) * REG_WIDTH'(BYTES));
  assign icb.cmd_wdata = head_words[word_q];
  assign icb.cmd_read  = 1'b0;
  assign icb.cmd_wmask = '1;
  assign icb.rsp_ready = 1'b1;

  assign write_oa_req = (state_q == S_REQ) || (state_q == S_BURST) || (state_q == S_DRAIN);
  assign write_done   = (state_q == S_DONE);
  assign oa_calc_over = ((state_q == S_DONE) && last_tile) || zero_over_q;
  assign oa_err       = err_q;

  // Row FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outstanding-write tracker and sticky error
  always_comb begin
    outst_d = outst_q;
    if (cmd_hs && !icb.rsp_valid)
      outst_d = outst_q + 1'b1;
    else if (!cmd_hs && icb.rsp_valid && (outst_q != '0))
      outst_d = outst_q - 1'b1;
    err_d = err_q;
    if (init_acc)
      err_d = 1'b0;
    else if (icb.rsp_valid && icb.rsp_err)
      err_d = 1'b1;
    hold_d = cmd_vld && !icb.cmd_ready;
  end

  // Main FSM next-state
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    row_d       = row_q;
    row_addr_d  = row_addr_q;
    stride_d    = stride_q;
    tiles_d     = tiles_q;
    tile_d      = tile_q;
    zero_over_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_cfg_oa) begin
          stride_d   = cfg_oa_stride;
          tiles_d    = cfg_tile_count;
          tile_d     = '0;
          row_addr_d = cfg_oa_base;
          word_d     = '0;
          row_d      = '0;
          if (cfg_tile_count == '0) zero_over_d = 1'b1;
          else                      state_d     = S_WAIT;
        end
      end
      S_WAIT:  if (cnt_q >= CW'(SIZE)) state_d = S_REQ;
      S_REQ:   if (write_oa_granted)   state_d = S_BURST;
      S_BURST: begin
        if (cmd_hs) begin
          if (last_word) begin
            word_d = '0;
            // Row addresses accumulate across tiles, so tile t starts
            // at base + t*SIZE*stride without a multiplier.
            row_addr_d = row_addr_q + stride_q;
            if (last_row) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_DRAIN: if (outst_q == '0) state_d = S_DONE;
      S_DONE: begin
        tile_d  = tile_q + 1'b1;
        state_d = last_tile ? S_IDLE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      row_q       <= '0;
      row_addr_q  <= '0;
      stride_q    <= '0;
      tiles_q     <= '0;
      tile_q      <= '0;
      outst_q     <= '0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      zero_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      row_q       <= row_d;
      row_addr_q  <= row_addr_d;
      stride_q    <= stride_d;
      tiles_q     <= tiles_d;
      tile_q      <= tile_d;
      outst_q     <= outst_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      zero_over_q <= zero_over_d;
    end
  end

  // Row storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= oa_row_data;
  end
endmodule

// File: tb/tb_oa_writer.sv
// Self-checking bench for oa_writer: scoreboard of expected ICB writes, monitor on the falling edge.
// Latency: n/a.
// Backpressure: bench models cmd_ready (fixed or random) and delayed single-beat responses.
module tb_oa_writer;
  localparam int SIZE = 16;
  localparam int BW   = 32;
  localparam int RW   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init_cfg_oa;
  logic [RW-1:0]   cfg_oa_base, cfg_oa_stride, cfg_tile_count;
  logic            oa_row_valid;
  logic [SIZE*8-1:0] oa_row_data;
  logic            oa_row_ready, fifo_full_flag, write_oa_req, write_oa_granted;
  logic            write_done, oa_calc_over, oa_err;

  oa_writer_if #(.REG_WIDTH(RW), .BUS_WIDTH(BW)) bus ();

  oa_writer #(.SIZE(SIZE), .BUS_WIDTH(BW), .REG_WIDTH(RW), .ROW_DEPTH(2*SIZE), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_cfg_oa(init_cfg_oa), .cfg_oa_base(cfg_oa_base),
    .cfg_oa_stride(cfg_oa_stride), .cfg_tile_count(cfg_tile_count), .oa_row_valid(oa_row_valid),
    .oa_row_data(oa_row_data), .oa_row_ready(oa_row_ready), .fifo_full_flag(fifo_full_flag),
    .write_oa_req(write_oa_req), .write_oa_granted(write_oa_granted), .write_done(write_done),
    .oa_calc_over(oa_calc_over), .oa_err(oa_err), .icb(bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int hs_cnt = 0, done_cnt = 0, over_cnt = 0;
  int last_done_cyc = -1, last_over_cyc = -1, first_hs = -1, last_hs = -1;
  int tb_outst = 0, outst_viol = 0, stab_viol = 0, drop_viol = 0;
  int rsp_delay = 0, err_at = -1;
  bit rnd_ready = 0, drop_win = 0, pend = 0;
  logic [31:0] p_addr, p_data;
  logic [31:0] exp_addr_q[$], exp_data_q[$], addr_log[$], data_log[$];
  int  resp_due[$];
  bit  resp_errq[$];
  logic [RW-1:0] m_base, m_stride;
  int g = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [SIZE*8-1:0] mk_row(int idx, int salt);
    logic [SIZE*8-1:0] r;
    for (int i = 0; i < SIZE; i++) r[8*i +: 8] = 8'((idx * SIZE + i + salt) & 255);
    return r;
  endfunction

  // cycle counter
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // cmd_ready driver
  initial begin
    bus.cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.cmd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // response driver: one response per cycle, each due rsp_delay cycles after its command
  initial begin
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = resp_errq[0];
        void'(resp_due.pop_front());
        void'(resp_errq.pop_front());
      end else begin
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (drop_win && bus.cmd_valid && !pend) drop_viol++;
      if (pend && !(bus.cmd_valid && bus.cmd_addr == p_addr && bus.cmd_wdata == p_data)) stab_viol++;
      pend   = bus.cmd_valid && !bus.cmd_ready;
      p_addr = bus.cmd_addr;
      p_data = bus.cmd_wdata;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (tb_outst >= 4) outst_viol++;
        addr_log.push_back(bus.cmd_addr);
        data_log.push_back(bus.cmd_wdata);
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr 0x%0h, no write expected", bus.cmd_addr);
        end else begin
          check("cmd_addr", 64'(bus.cmd_addr), 64'(exp_addr_q.pop_front()));
          check("cmd_wdata", 64'(bus.cmd_wdata), 64'(exp_data_q.pop_front()));
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        resp_due.push_back(cyc + 1 + rsp_delay);
        resp_errq.push_back(hs_cnt == err_at);
        hs_cnt++;
        tb_outst++;
      end
      if (bus.rsp_valid && tb_outst > 0) tb_outst--;
      if (write_done)   begin done_cnt++; last_done_cyc = cyc; end
      if (oa_calc_over) begin over_cnt++; last_over_cyc = cyc; end
    end
  end

  task automatic do_init(logic [RW-1:0] base, logic [RW-1:0] stride, logic [RW-1:0] tiles);
    init_cfg_oa = 1'b1; cfg_oa_base = base; cfg_oa_stride = stride; cfg_tile_count = tiles;
    m_base = base; m_stride = stride; g = 0;
    @(posedge clk); #1;
    init_cfg_oa = 1'b0;
  endtask

  task automatic push_rows(int n, int salt);
    logic [SIZE*8-1:0] r;
    for (int k = 0; k < n; k++) begin
      r = mk_row(g, salt);
      for (int w = 0; w < SIZE*8/BW; w++) begin
        exp_addr_q.push_back(m_base + RW'(g) * m_stride + RW'(4 * w));
        exp_data_q.push_back(r[BW*w +: BW]);
      end
      g++;
      oa_row_valid = 1'b1;
      oa_row_data  = r;
      for (int t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (oa_row_ready) break;
      end
      if (!oa_row_ready) begin
        tests++; fails++;
        $display("FAIL push_timeout: oa_row_ready got 0 required 1");
      end
      @(posedge clk); #1;
    end
    oa_row_valid = 1'b0;
  endtask

  task automatic wait_over(int target);
    int t;
    for (t = 0; t < 3000 && over_cnt < target; t++) @(posedge clk);
    if (over_cnt < target) begin
      tests++; fails++;
      $display("FAIL over_timeout: oa_calc_over count got %0d required %0d", over_cnt, target);
    end
    #1;
  endtask

  task automatic wait_hs(int target);
    int t;
    for (t = 0; t < 2000 && hs_cnt < target; t++) @(posedge clk);
    if (hs_cnt < target) begin
      tests++; fails++;
      $display("FAIL hs_timeout: handshakes got %0d required %0d", hs_cnt, target);
    end
    #1;
  endtask

  int h0, d0, o0;

  initial begin
    rst_n = 1'b0; init_cfg_oa = 1'b0; cfg_oa_base = '0; cfg_oa_stride = '0; cfg_tile_count = '0;
    oa_row_valid = 1'b0; oa_row_data = '0; write_oa_granted = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_row_ready", 64'(oa_row_ready), 1);
    check("rst_full", 64'(fifo_full_flag), 0);
    check("rst_req", 64'(write_oa_req), 0);
    check("rst_done_over", 64'({write_done, oa_calc_over}), 0);
    check("rst_err", 64'(oa_err), 0);
    check("rst_cmd_valid", 64'(bus.cmd_valid), 0);
    check("rst_const", 64'({bus.cmd_read, bus.rsp_ready, bus.cmd_wmask}), 64'h1F);
    @(posedge clk); #1;

    // T1 basic single tile
    h0 = hs_cnt; d0 = done_cnt; o0 = over_cnt; first_hs = -1;
    do_init(32'h1000, 32'd16, 32'd1);
    push_rows(16, 0);
    wait_over(o0 + 1);
    check("t1_done_cnt", 64'(done_cnt - d0), 1);
    check("t1_same_cycle", 64'(last_over_cyc), 64'(last_done_cyc));
    check("t1_throughput", 64'(last_hs - first_hs), 63);
    check("t1_first_addr", 64'(addr_log[h0]), 64'h1000);
    check("t1_first_word", 64'(data_log[h0]), 64'h03020100);
    check("t1_last_addr", 64'(addr_log[h0 + 63]), 64'h10FC);
    check("t1_sb_empty", 64'(exp_addr_q.size()), 0);

    // T2 two tiles, FIFO fills while grant is withheld
    write_oa_granted = 1'b0;
    h0 = hs_cnt; d0 = done_cnt; o0 = over_cnt;
    do_init(32'h1000, 32'd64, 32'd2);
    push_rows(32, 7);
    @(negedge clk);
    check("t2_full", 64'(fifo_full_flag), 1);
    check("t2_ready_low", 64'(oa_row_ready), 0);
    check("t2_req", 64'(write_oa_req), 1);
    @(posedge clk); #1;
    write_oa_granted = 1'b1;
    wait_over(o0 + 1);
    check("t2_done_cnt", 64'(done_cnt - d0), 2);
    check("t2_over_cnt", 64'(over_cnt - o0), 1);
    check("t2_tile1_addr", 64'(addr_log[h0 + 64]), 64'h1400);
    check("t2_same_cycle", 64'(last_over_cyc), 64'(last_done_cyc));
    check("t2_sb_empty", 64'(exp_addr_q.size()), 0);

    // T3 random cmd_ready, responses delayed 3 cycles
    rnd_ready = 1; rsp_delay = 3; outst_viol = 0; stab_viol = 0;
    d0 = done_cnt; o0 = over_cnt;
    do_init(32'h2000, 32'd16, 32'd1);
    push_rows(16, 3);
    wait_over(o0 + 1);
    check("t3_outst_le4", 64'(outst_viol), 0);
    check("t3_stable", 64'(stab_viol), 0);
    check("t3_done_cnt", 64'(done_cnt - d0), 1);
    check("t3_sb_empty", 64'(exp_addr_q.size()), 0);
    rnd_ready = 0; rsp_delay = 0;
    repeat (2) @(posedge clk); #1;

    // T4 grant drop after 10 words
    h0 = hs_cnt; o0 = over_cnt; drop_viol = 0;
    do_init(32'h4000, 32'd32, 32'd1);
    push_rows(16, 9);
    wait_hs(h0 + 10);
    write_oa_granted = 1'b0; drop_win = 1;
    repeat (5) @(posedge clk); #1;
    check("t4_words_at_drop", 64'(hs_cnt - h0), 10);
    drop_win = 0; write_oa_granted = 1'b1;
    wait_over(o0 + 1);
    check("t4_no_valid_in_drop", 64'(drop_viol), 0);
    check("t4_total_words", 64'(hs_cnt - h0), 64);
    check("t4_sb_empty", 64'(exp_addr_q.size()), 0);

    // T5a zero tiles
    d0 = done_cnt;
    do_init(32'h0, 32'd16, 32'd0);
    @(negedge clk);
    check("t5_zero_over", 64'(oa_calc_over), 1);
    @(negedge clk);
    check("t5_zero_over_end", 64'(oa_calc_over), 0);
    check("t5_zero_no_req", 64'(write_oa_req), 0);
    @(posedge clk); #1;
    check("t5_zero_no_done", 64'(done_cnt - d0), 0);

    // T5b error on word 7, init during BURST ignored
    h0 = hs_cnt; d0 = done_cnt; o0 = over_cnt; err_at = h0 + 7;
    do_init(32'h5000, 32'd32, 32'd1);
    push_rows(16, 11);
    @(negedge clk);
    check("t5_err_clear_start", 64'(oa_err), 0);
    wait_hs(h0 + 20);
    init_cfg_oa = 1'b1; cfg_oa_base = 32'h0; cfg_oa_stride = 32'd4; cfg_tile_count = 32'd5;
    @(posedge clk); #1;
    init_cfg_oa = 1'b0;
    wait_over(o0 + 1);
    @(negedge clk);
    check("t5_err_sticky", 64'(oa_err), 1);
    check("t5_done_cnt", 64'(done_cnt - d0), 1);
    check("t5_over_once", 64'(over_cnt - o0), 1);
    check("t5_sb_empty", 64'(exp_addr_q.size()), 0);
    @(posedge clk); #1;
    err_at = -1;
    do_init(32'h0, 32'd16, 32'd0);
    @(negedge clk);
    check("t5_err_cleared", 64'(oa_err), 0);
    @(posedge clk); #1;

    // T6 reset mid-burst
    h0 = hs_cnt;
    do_init(32'h6000, 32'd16, 32'd1);
    push_rows(16, 5);
    wait_hs(h0 + 20);
    rst_n = 1'b0;
    #1;
    check("t6_cmd_valid", 64'(bus.cmd_valid), 0);
    check("t6_req", 64'(write_oa_req), 0);
    check("t6_status", 64'({write_done, oa_calc_over, oa_err, fifo_full_flag}), 0);
    check("t6_row_ready", 64'(oa_row_ready), 1);
    exp_addr_q.delete(); exp_data_q.delete(); resp_due.delete(); resp_errq.delete();
    tb_outst = 0; pend = 0;
    d0 = done_cnt; o0 = over_cnt;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_no_done", 64'(done_cnt - d0), 0);
    do_init(32'h3000, 32'd16, 32'd1);
    push_rows(16, 2);
    wait_over(o0 + 1);
    check("t6_done_after", 64'(done_cnt - d0), 1);
    check("t6_sb_empty", 64'(exp_addr_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
